vending_ctrl: RTL

VENDING_CTRL -- requirements
Module: vending_ctrl

---
 rtl/vend_pkg.sv | 22 ++
 rtl/bin_to_bcd2.sv | 23 ++
 rtl/vending_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// Optional feature macro used by vending_ctrl: VEND_AUTO_CHANGE_EN.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    CHANGE
  } state_t;

  localparam logic [6:0] COIN_1  = 7'd1;
  localparam logic [6:0] COIN_5  = 7'd5;
  localparam logic [6:0] COIN_10 = 7'd10;
  localparam logic [6:0] BAL_MAX = 7'd99;

  localparam logic [3:0] CODE_J     = 4'd10;
  localparam logic [3:0] CODE_U     = 4'd11;
  localparam logic [3:0] CODE_C     = 4'd13;
  localparam logic [3:0] CODE_F     = 4'd14;
  localparam logic [3:0] CODE_BLANK = 4'd15;

endpackage

// File: rtl/bin_to_bcd2.sv
// Combinational 0..99 binary to two-digit BCD converter.
// Repeated subtraction keeps the logic to small compare/subtract stages.
module bin_to_bcd2 (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] rem;

  always_comb begin
    tens = 4'd0;
    rem  = bin;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    ones = rem[3:0];
  end

endmodule

// File: rtl/vending_ctrl.sv
// Coin-operated juice/coffee vending controller with change return.
// Define VEND_AUTO_CHANGE_EN to return leftover credit after each sale.
module vending_ctrl
  import vend_pkg::*;
#(
  parameter int JUICE_PRICE  = 25,
  parameter int COFFEE_PRICE = 30,
  parameter int DROP_CYCLES  = 16,
  parameter int CHANGE_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       money_1,
  input  logic       money_5,
  input  logic       money_10,
  input  logic       juice,
  input  logic       coffee,
  input  logic       cancel,
  output logic       drop_juice,
  output logic       drop_coffee,
  output logic       ret_1,
  output logic       ret_5,
  output logic       ret_10,
  output logic       busy,
  output logic [3:0] bcd3,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0
);

  localparam int CW = 16;
  localparam logic [CW-1:0] DROP_LAST = CW'(DROP_CYCLES - 1);
  localparam logic [CW-1:0] CHG_LAST  = CW'(CHANGE_GAP - 1);
  localparam logic [6:0] JP = 7'(JUICE_PRICE);
  localparam logic [6:0] CP = 7'(COFFEE_PRICE);

  state_t        state, state_n;
  logic [6:0]    bal, bal_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          sel_cof, sel_cof_n;
  logic          r1_n, r5_n, r10_n;
  logic [3:0]    tens_n, ones_n;

  always_comb begin
    state_n   = state;
    bal_n     = bal;
    cnt_n     = cnt;
    sel_cof_n = sel_cof;
    r1_n      = 1'b0;
    r5_n      = 1'b0;
    r10_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cancel) begin
          if (bal != 7'd0) begin
            state_n = CHANGE;
            cnt_n   = CHG_LAST;
          end
        end else if (coffee) begin
          if (bal >= CP) begin
            bal_n     = bal - CP;
            state_n   = DISPENSE;
            sel_cof_n = 1'b1;
            cnt_n     = DROP_LAST;
          end
        end else if (juice) begin
          if (bal >= JP) begin
            bal_n     = bal - JP;
            state_n   = DISPENSE;
            sel_cof_n = 1'b0;
            cnt_n     = DROP_LAST;
          end
        end else if (money_10) begin
          if (bal <= BAL_MAX - COIN_10) bal_n = bal + COIN_10;
          else r10_n = 1'b1;
        end else if (money_5) begin
          if (bal <= BAL_MAX - COIN_5) bal_n = bal + COIN_5;
          else r5_n = 1'b1;
        end else if (money_1) begin
          if (bal <= BAL_MAX - COIN_1) bal_n = bal + COIN_1;
          else r1_n = 1'b1;
        end
      end
      DISPENSE: begin
        if (cnt == '0) begin
`ifdef VEND_AUTO_CHANGE_EN
          if (bal != 7'd0) begin
            state_n = CHANGE;
            cnt_n   = CHG_LAST;
          end else begin
            state_n = IDLE;
          end
`else
          state_n = IDLE;
`endif
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      CHANGE: begin
        if (bal == 7'd0) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          cnt_n = CHG_LAST;
          // greedy: largest coin not exceeding the balance
          if (bal >= COIN_10) begin
            bal_n = bal - COIN_10;
            r10_n = 1'b1;
          end else if (bal >= COIN_5) begin
            bal_n = bal - COIN_5;
            r5_n  = 1'b1;
          end else begin
            bal_n = bal - COIN_1;
            r1_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  bin_to_bcd2 u_bcd (
    .bin  (bal_n),
    .tens (tens_n),
    .ones (ones_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bal         <= 7'd0;
      cnt         <= '0;
      sel_cof     <= 1'b0;
      drop_juice  <= 1'b0;
      drop_coffee <= 1'b0;
      ret_1       <= 1'b0;
      ret_5       <= 1'b0;
      ret_10      <= 1'b0;
      busy        <= 1'b0;
      bcd3        <= CODE_BLANK;
      bcd2        <= CODE_BLANK;
      bcd1        <= 4'd0;
      bcd0        <= 4'd0;
    end else begin
      state       <= state_n;
      bal         <= bal_n;
      cnt         <= cnt_n;
      sel_cof     <= sel_cof_n;
      drop_juice  <= (state_n == DISPENSE) && !sel_cof_n;
      drop_coffee <= (state_n == DISPENSE) && sel_cof_n;
      ret_1       <= r1_n;
      ret_5       <= r5_n;
      ret_10      <= r10_n;
      busy        <= (state_n != IDLE);
      if (state_n == DISPENSE) begin
        bcd3 <= sel_cof_n ? CODE_C : CODE_J;
        bcd2 <= sel_cof_n ? CODE_F : CODE_U;
      end else begin
        bcd3 <= CODE_BLANK;
        bcd2 <= CODE_BLANK;
      end
      bcd1        <= tens_n;
      bcd0        <= ones_n;
    end
  end

endmodule
